// File: rtl/period_meter_pkg.sv
// Shared types and defaults for the period meter.
package period_meter_pkg;
  localparam int CNT_W_DEF = 27;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_EDGE = 2'd1,
    COUNT     = 2'd2,
    HOLD      = 2'd3
  } state_t;
endpackage

// File: rtl/period_meter_edge.sv
// Synchronizer, optional 3-sample glitch filter, and rising-edge pulse.
// Filter is built when PERIOD_METER_GLITCH_FILTER_EN is defined.
module period_meter_edge (
  input  logic clk,
  input  logic rst,
  input  logic sig_in,
  output logic rise
);
  logic [1:0] sync;
  logic       lvl;
  logic       lvl_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync <= '0;
    else      sync <= {sync[0], sig_in};
  end

`ifdef PERIOD_METER_GLITCH_FILTER_EN
  // Current synchronized sample plus the two before it must agree to move the level.
  logic [1:0] hist;
  logic       filt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      filt <= 1'b0;
    end else begin
      hist <= {hist[0], sync[1]};
      if (sync[1] && (hist == 2'b11))       filt <= 1'b1;
      else if (!sync[1] && (hist == 2'b00)) filt <= 1'b0;
    end
  end

  assign lvl = filt;
`else
  assign lvl = sync[1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lvl_d <= 1'b0;
    else      lvl_d <= lvl;
  end

  assign rise = lvl & ~lvl_d;
endmodule

// File: rtl/period_meter.sv
// Measures clk cycles between two consecutive rising edges of sig_in.
// Optional glitch filter: PERIOD_METER_GLITCH_FILTER_EN (see period_meter_edge).
module period_meter
  import period_meter_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] meas_period,
  output logic             meas_overflow,
  output logic             busy
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             rise;

  period_meter_edge u_edge (
    .clk    (clk),
    .rst    (rst),
    .sig_in (sig_in),
    .rise   (rise)
  );

  // cnt holds edge-to-edge cycles minus one, so the capture adds the edge cycle back.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      cnt           <= '0;
      meas_valid    <= 1'b0;
      meas_period   <= '0;
      meas_overflow <= 1'b0;
      busy          <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state <= WAIT_EDGE;
            busy  <= 1'b1;
          end
        end
        WAIT_EDGE: begin
          if (rise) begin
            state <= COUNT;
            cnt   <= '0;
          end
        end
        COUNT: begin
          if (rise) begin
            meas_period   <= (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
            meas_overflow <= (cnt == CNT_MAX);
            meas_valid    <= 1'b1;
            state         <= HOLD;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (meas_ready) begin
            meas_valid    <= 1'b0;
            meas_overflow <= 1'b0;
            busy          <= 1'b0;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: default-width and 4-bit instances share all inputs.
module tb_period_meter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sig_in = 1'b0;
  logic        start = 1'b0;
  logic        meas_ready = 1'b0;
  logic        meas_valid, meas_overflow, busy;
  logic [26:0] meas_period;
  logic        s_valid, s_overflow, s_busy;
  logic [3:0]  s_period;

  int errors = 0;
  int checks = 0;

  bit wave[$];
  int edges[$];
  int vcyc, vlen, unstable, vrises, viol;
  logic [26:0] per_m;
  logic [3:0]  per_s;
  logic        ovf_m, ovf_s;

  always #5 clk = ~clk;

  period_meter dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .meas_ready(meas_ready),
    .meas_valid(meas_valid), .meas_period(meas_period), .meas_overflow(meas_overflow), .busy(busy)
  );

  period_meter #(.CNT_W(4)) dut_s (
    .clk(clk), .rst(rst), .sig_in(sig_in), .start(start), .meas_ready(meas_ready),
    .meas_valid(s_valid), .meas_period(s_period), .meas_overflow(s_overflow), .busy(s_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: rising edges of the level seen after the optional 3-equal-sample rule.
  function automatic void edges_of();
    bit lvl = 1'b0;
    bit prev = 1'b0;
    edges.delete();
    for (int i = 0; i < wave.size(); i++) begin
`ifdef PERIOD_METER_GLITCH_FILTER_EN
      if (i >= 2 && wave[i] == wave[i-1] && wave[i-1] == wave[i-2]) lvl = wave[i];
`else
      lvl = wave[i];
`endif
      if (lvl && !prev) edges.push_back(i);
      prev = lvl;
    end
  endfunction

  task automatic build_wave(input int lead, input int p, input int w, input int n);
    wave.delete();
    for (int i = 0; i < lead; i++) wave.push_back(1'b0);
    for (int k = 0; k < n; k++)
      for (int i = 0; i < p; i++) wave.push_back(i < w);
  endtask

  task automatic arm();
    @(posedge clk); #1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    chk("busy_after_start", {busy, s_busy}, 2'b11);
  endtask

  task automatic play(input int hold, input bit poke);
    bit prev_v = 1'b0;
    edges_of();
    vcyc = -1; vlen = 0; unstable = 0; vrises = 0;
    for (int i = 0; i < wave.size() + hold + 40; i++) begin
      @(posedge clk); #1;
      start  = 1'b0;
      sig_in = (i < wave.size()) ? wave[i] : 1'b0;
      if (meas_valid) begin
        vlen++;
        if (vcyc < 0) begin
          vcyc = i; per_m = meas_period; ovf_m = meas_overflow;
          per_s = s_period; ovf_s = s_overflow;
        end else if (meas_period !== per_m || meas_overflow !== ovf_m ||
                     s_period !== per_s || s_overflow !== ovf_s) begin
          unstable++;
        end
      end
      if (meas_valid && !prev_v) vrises++;
      prev_v = meas_valid;
      meas_ready = (vcyc >= 0 && i >= vcyc + hold);
      if (poke && (i == 2 || (edges.size() > 0 && i == edges[0] + 15) ||
                   (vcyc >= 0 && i == vcyc + hold)))
        start = 1'b1;
    end
    start = 1'b0;
    meas_ready = 1'b0;
  endtask

  task automatic check_meas(input string tag, input int hold);
    int p;
    p = (edges.size() >= 2) ? edges[1] - edges[0] : 0;
    chk({tag, "_valid_seen"}, (vcyc >= 0), 1);
    chk({tag, "_period"}, per_m, p);
    chk({tag, "_ovf"}, ovf_m, 0);
    chk({tag, "_period_w4"}, per_s, (p > 15) ? 15 : p);
    chk({tag, "_ovf_w4"}, ovf_s, (p > 15));
    chk({tag, "_valid_len"}, vlen, hold + 1);
    chk({tag, "_stable"}, unstable, 0);
    chk({tag, "_vld_match"}, s_valid, meas_valid);
    chk({tag, "_idle"}, {busy, s_busy}, 2'b00);
  endtask

  initial begin
    int p, w, lead, hold;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", {meas_valid, s_valid}, 2'b00);
    chk("rst_period", meas_period, 0);
    chk("rst_period_w4", s_period, 0);
    chk("rst_ovf", {meas_overflow, s_overflow}, 2'b00);
    chk("rst_busy", {busy, s_busy}, 2'b00);
    @(posedge clk); #1; rst = 1'b1;
    repeat (2) @(posedge clk);

    arm(); build_wave(10, 100, 5, 2); play(0, 1'b0); check_meas("p100", 0);
    arm(); build_wave(10, 40, 5, 2);  play(0, 1'b0); check_meas("p40", 0);
    chk("p40_w4_direct", {ovf_s, per_s}, {1'b1, 4'd15});
    arm(); build_wave(10, 70, 5, 4);  play(20, 1'b0); check_meas("hold20", 20);

    // Reset in the middle of a measurement.
    arm();
    for (int i = 0; i < 45; i++) begin
      @(posedge clk); #1; sig_in = (i >= 5 && i < 15);
    end
    #2; rst = 1'b0; #1;
    chk("midrst_valid", {meas_valid, s_valid}, 2'b00);
    chk("midrst_period", {meas_period, s_period}, 0);
    chk("midrst_ovf", {meas_overflow, s_overflow}, 2'b00);
    chk("midrst_busy", {busy, s_busy}, 2'b00);
    @(posedge clk); #1; rst = 1'b1;
    viol = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1; sig_in = ((i % 20) < 5);
      if (busy || s_busy || meas_valid || s_valid) viol++;
    end
    sig_in = 1'b0;
    chk("postrst_idle", viol, 0);
    repeat (5) @(posedge clk);
    arm(); build_wave(10, 50, 5, 2); play(0, 1'b0); check_meas("p50", 0);

    // Two-cycle glitch 10 cycles into a 64-cycle period.
    wave.delete();
    for (int i = 0; i < 140; i++)
      wave.push_back((i >= 20 && i < 25) || (i >= 30 && i < 32) || (i >= 84 && i < 89));
    arm(); play(0, 1'b0); check_meas("glitch", 0);

    // Start pulses in WAIT_EDGE, COUNT, and at acceptance must not re-arm.
    arm(); build_wave(20, 60, 5, 4); play(0, 1'b1); check_meas("poke", 0);
    chk("poke_rises", vrises, 1);

    for (int r = 0; r < 8; r++) begin
      p    = $urandom_range(120, 6);
      w    = $urandom_range(p - 3, 3);
      lead = $urandom_range(10, 2);
      hold = $urandom_range(5, 0);
      arm(); build_wave(lead, p, w, 2); play(hold, 1'b0);
      check_meas($sformatf("rnd%0d_p%0d", r, p), hold);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/period_meter.md
PERIOD_METER -- requirements
Module: period_meter

Interface
REQ-001 Parameter CNT_W, default 27, sets the measurement counter and result width in bits.
REQ-002 clk  input  1  single system clock; all logic on its rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-low.
REQ-004 sig_in  input  1  external signal to be measured, asynchronous to clk.
REQ-005 start  input  1  single-cycle request to arm one measurement.
REQ-006 meas_ready  input  1  consumer accepts the result.
REQ-007 meas_valid  output  1  result available.
REQ-008 meas_period  output  CNT_W  clk cycles between two consecutive rising edges of sig_in.
REQ-009 meas_overflow  output  1  measured period saturated.
REQ-010 busy  output  1  high whenever the state is not IDLE.

Function
REQ-011 sig_in SHALL pass through a 2-flop synchronizer; a rising edge is detected when the synchronized level is 1 and its one-cycle-delayed copy is 0.
REQ-012 The FSM SHALL have exactly four states: IDLE, WAIT_EDGE, COUNT, HOLD.
REQ-013 IDLE: start=1 -> WAIT_EDGE; otherwise stay.
REQ-014 WAIT_EDGE: on the first detected edge -> COUNT, counter loaded with 0; no timeout applies.
REQ-015 COUNT: counter SHALL increment by 1 each cycle with no detected edge and SHALL saturate at 2^CNT_W-1.
REQ-016 COUNT: on the next detected edge, meas_period SHALL load counter+1, saturated at 2^CNT_W-1; meas_valid SHALL go to 1 on the same clock; the FSM SHALL go to HOLD.
REQ-017 Edges at cycles t and t+P SHALL yield meas_period=P; synchronizer latency SHALL NOT bias the result.
REQ-018 meas_overflow SHALL be 1 with meas_valid when the counter saturated during COUNT; otherwise it SHALL be 0.
REQ-019 HOLD: meas_period and meas_overflow SHALL remain stable while meas_valid=1 and meas_ready=0.
REQ-020 HOLD: when meas_valid and meas_ready are both 1, the FSM SHALL go to IDLE and meas_valid SHALL be 0 on the next cycle.
REQ-021 start SHALL be ignored in every state except IDLE, including a start that coincides with acceptance in HOLD.
REQ-022 Edges detected in IDLE or HOLD SHALL be ignored.
REQ-023 meas_ready outside HOLD SHALL have no effect.

Reset
REQ-024 rst=0 SHALL immediately force state IDLE, counter 0, synchronizer and filter flops 0, meas_valid 0, meas_period 0, meas_overflow 0, busy 0.
REQ-025 Reset asserted mid-measurement SHALL discard the measurement; after release the block SHALL wait in IDLE for a new start.

Configuration
REQ-026 Macro PERIOD_METER_GLITCH_FILTER_EN defined: a 3-sample filter SHALL follow the synchronizer; the filtered level changes only after 3 consecutive equal samples, and edge detection uses the filtered level.
REQ-027 With the filter, pulses shorter than 3 clk cycles SHALL be rejected and edge detection latency SHALL grow by 3 cycles.
REQ-028 Macro undefined: no filter logic SHALL exist and edge detection SHALL use the synchronizer output directly.

Structure
REQ-029 Package period_meter_pkg SHALL hold the FSM state enum typedef and the CNT_W default constant.
REQ-030 Sub-module period_meter_edge SHALL contain the synchronizer, the optional filter and the rising-edge detector, and SHALL output a 1-cycle edge pulse.

Verification
REQ-031 start, then sig_in rising edges 100 cycles apart, meas_ready=1 -> meas_period=100, meas_overflow=0, meas_valid high for 1 cycle, then IDLE.
REQ-032 CNT_W=4, edges 40 cycles apart -> meas_period=15, meas_overflow=1.
REQ-033 meas_ready=0 for 20 cycles after meas_valid, with further edges on sig_in -> meas_period is unchanged; meas_ready=1 -> meas_valid=0 on the next cycle.
REQ-034 rst=0 pulse 30 cycles into COUNT -> all outputs 0 at once; after release and a new start, edges 50 cycles apart -> meas_period=50.
REQ-035 Filter enabled: a 2-cycle glitch at 10 cycles into a 64-cycle period -> meas_period=64; filter disabled: same stimulus -> meas_period=10.
REQ-036 start pulses in WAIT_EDGE, in COUNT, and coincident with acceptance in HOLD -> no re-arm, and busy=0 after acceptance.
